// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory-side bus responder.
package mem_responder_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } bus_state_e;

  localparam word_t MEM_ERR_DATA = 16'hFFFF;

  // True when every address bit above the decoded range is zero.
  function automatic logic addr_in_range(input word_t a, input int aw);
    return (a >> aw) == 16'h0000;
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word-wide RAM: synchronous write port, combinational read port, no reset.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  word_t             i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output word_t             o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  word_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// Request/acknowledge bus responder: captures a request, waits WAIT_CYC cycles,
// performs the RAM access, then pulses o_ack (with o_err for undecoded addresses).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic        o_ack,
  output logic [15:0] o_rdata,
  output logic        o_err
);

  localparam logic [3:0] WAIT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  bus_state_e r_state;
  logic [3:0] r_cnt;
  logic       r_we;
  word_t      r_addr;
  word_t      r_wdata;
  word_t      r_rdata;
  logic       r_ack;
  logic       r_err;

  logic       w_fire;
  logic       w_we;
  logic       w_in_range;
  logic       w_mem_we;
  word_t      w_addr;
  word_t      w_wdata;
  word_t      w_mem_rdata;

  // With no wait states the access happens on the capture edge itself, so the
  // live bus attributes are used; otherwise the captured copies are.
  assign w_we    = (r_state == IDLE) ? i_we    : r_we;
  assign w_addr  = (r_state == IDLE) ? i_addr  : r_addr;
  assign w_wdata = (r_state == IDLE) ? i_wdata : r_wdata;

  assign w_fire = ((r_state == IDLE) && i_req && (WAIT_CYC == 0)) ||
                  ((r_state == WAIT) && (r_cnt == 4'd0));

  assign w_in_range = addr_in_range(w_addr, ADDR_W);
  assign w_mem_we   = w_fire && w_we && w_in_range;

  mem_array #(
    .ADDR_W(ADDR_W)
  ) u_mem (
    .i_clk  (i_clk),
    .i_we   (w_mem_we),
    .i_waddr(w_addr[ADDR_W-1:0]),
    .i_wdata(w_wdata),
    .i_raddr(w_addr[ADDR_W-1:0]),
    .o_rdata(w_mem_rdata)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
      r_rdata <= 16'h0000;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req) begin
            r_we    <= i_we;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            if (WAIT_CYC == 0) begin
              r_state <= ACK;
            end else begin
              r_state <= WAIT;
              r_cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ACK;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ACK: begin
          r_ack   <= 1'b1;
          r_err   <= ~addr_in_range(r_addr, ADDR_W);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // Read data is held until the next read completes; writes leave it alone.
      if (w_fire && !w_we) begin
        r_rdata <= w_in_range ? w_mem_rdata : MEM_ERR_DATA;
      end
    end
  end

  assign o_ack   = r_ack;
  assign o_rdata = r_rdata;
  assign o_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances (WAIT_CYC 0..3) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_mem_responder;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst   [N];
  logic        req   [N];
  logic        we    [N];
  logic [15:0] addr  [N];
  logic [15:0] wdata [N];
  logic [15:0] rdata [N];
  logic        ack   [N];
  logic        err   [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(
      .ADDR_W  (8),
      .WAIT_CYC(g)
    ) dut (
      .i_clk  (clk),
      .i_rst  (rst[g]),
      .i_req  (req[g]),
      .i_we   (we[g]),
      .i_addr (addr[g]),
      .i_wdata(wdata[g]),
      .o_ack  (ack[g]),
      .o_rdata(rdata[g]),
      .o_err  (err[g])
    );
  end

  // Model: outstanding transactions with the edge number of their ack,
  // memory image and last completed read value per instance.
  typedef struct {
    int          k;
    int          ack_e;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wd;
  } txn_t;

  txn_t        mq [$];
  logic [15:0] mmem [N][256];
  logic [15:0] held [N];
  int          next_free [N];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit in_rng(input logic [15:0] a);
    return a[15:8] == 8'h00;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle compare, sampled 1 time unit after each rising edge.
  initial begin
    int   idx;
    bit   pend;
    txn_t t;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        idx  = -1;
        pend = 1'b0;
        foreach (mq[i]) begin
          if (mq[i].k == k) begin
            pend = 1'b1;
            if (mq[i].ack_e == cyc) idx = i;
          end
        end
        if (idx >= 0) begin
          t = mq[idx];
          mq.delete(idx);
          if (t.we) begin
            if (in_rng(t.addr)) mmem[k][t.addr[7:0]] = t.wd;
          end else begin
            held[k] = in_rng(t.addr) ? mmem[k][t.addr[7:0]] : 16'hFFFF;
          end
          chk($sformatf("ack_w%0d", k), 16'(ack[k]), 16'h1);
          chk($sformatf("err_w%0d", k), 16'(err[k]), 16'(!in_rng(t.addr)));
          chk($sformatf("rdata_ack_w%0d", k), rdata[k], held[k]);
        end else begin
          chk($sformatf("noack_w%0d", k), 16'(ack[k]), 16'h0);
          chk($sformatf("noerr_w%0d", k), 16'(err[k]), 16'h0);
          if (!pend) chk($sformatf("rdata_hold_w%0d", k), rdata[k], held[k]);
        end
      end
    end
  end

  // Issue one transaction on instance k (called at a falling edge); returns at
  // the falling edge inside the ack cycle. hold keeps i_req high afterwards.
  task automatic txn(input int k, input bit w, input logic [15:0] a, input logic [15:0] d,
                     input bit hold, input bit drop, output int cap);
    txn_t t;
    int   ae;
    we[k]    = w;
    addr[k]  = a;
    wdata[k] = d;
    req[k]   = 1'b1;
    cap = (cyc + 1 > next_free[k]) ? cyc + 1 : next_free[k];
    ae  = cap + 1 + k;
    t.k = k; t.ack_e = ae; t.we = w; t.addr = a; t.wd = d;
    mq.push_back(t);
    next_free[k] = ae + 1;
    while (cyc < ae) begin
      @(negedge clk);
      if (drop && cyc == cap) req[k] = 1'b0;
    end
    if (!hold) req[k] = 1'b0;
  endtask

  task automatic do_reset(input int k, input int n);
    txn_t keep [$];
    rst[k] = 1'b1;
    req[k] = 1'b0;
    foreach (mq[i]) if (mq[i].k != k) keep.push_back(mq[i]);
    mq      = keep;
    held[k] = 16'h0000;
    repeat (n) @(negedge clk);
    rst[k]       = 1'b0;
    next_free[k] = cyc + 1;
  endtask

  initial begin
    int cap;
    bit h;
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0;
      addr[k] = 16'h0; wdata[k] = 16'h0;
      held[k] = 16'h0000; next_free[k] = 0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) rst[k] = 1'b0;
    repeat (3) @(negedge clk);

    // Preload every word with zero (back-to-back), then addr 2 = 0x0042.
    for (int k = 0; k < N; k++) begin
      for (int a = 0; a < 256; a++) txn(k, 1'b1, 16'(a), 16'h0000, 1'b1, 1'b0, cap);
      txn(k, 1'b1, 16'h0002, 16'h0042, 1'b0, 1'b0, cap);
      repeat (2) @(negedge clk);
    end

    // Write then read, one wait state.
    txn(1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, cap);
    chk("t2_wr_ack", 16'(ack[1]), 16'h1);
    repeat (2) @(negedge clk);
    txn(1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, cap);
    chk("t2_rd_ack", 16'(ack[1]), 16'h1);
    chk("t2_rd_data", rdata[1], 16'hBEEF);
    chk("t2_rd_err", 16'(err[1]), 16'h0);

    // Back-to-back, zero wait states.
    repeat (2) @(negedge clk);
    txn(0, 1'b1, 16'h0003, 16'hA5A5, 1'b1, 1'b0, cap);
    txn(0, 1'b1, 16'h0004, 16'h5A5A, 1'b1, 1'b0, cap);
    txn(0, 1'b0, 16'h0003, 16'h0000, 1'b1, 1'b0, cap);
    chk("t3_rd3", rdata[0], 16'hA5A5);
    txn(0, 1'b0, 16'h0004, 16'h0000, 1'b0, 1'b0, cap);
    chk("t3_rd4", rdata[0], 16'h5A5A);
    repeat (4) @(negedge clk);
    chk("t3_hold", rdata[0], 16'h5A5A);

    // Out-of-range accesses.
    txn(1, 1'b1, 16'h0105, 16'h1234, 1'b0, 1'b0, cap);
    chk("t4_wr_err", 16'(err[1]), 16'h1);
    txn(1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, cap);
    chk("t4_rd5_data", rdata[1], 16'h0000);
    chk("t4_rd5_err", 16'(err[1]), 16'h0);
    txn(1, 1'b0, 16'h0105, 16'h0000, 1'b0, 1'b0, cap);
    chk("t4_oor_data", rdata[1], 16'hFFFF);
    chk("t4_oor_err", 16'(err[1]), 16'h1);

    // Reset while a write is waiting: no ack, no write.
    @(negedge clk);
    we[3] = 1'b1; addr[3] = 16'h0007; wdata[3] = 16'hCAFE; req[3] = 1'b1;
    repeat (2) @(negedge clk);
    do_reset(3, 1);
    repeat (6) @(negedge clk);
    txn(3, 1'b0, 16'h0007, 16'h0000, 1'b0, 1'b0, cap);
    chk("t5_ack", 16'(ack[3]), 16'h1);
    chk("t5_rd7", rdata[3], 16'h0000);

    // Request dropped during wait still completes once.
    repeat (2) @(negedge clk);
    txn(2, 1'b0, 16'h0002, 16'h0000, 1'b0, 1'b1, cap);
    chk("t6_ack", 16'(ack[2]), 16'h1);
    chk("t6_rd2", rdata[2], 16'h0042);
    repeat (6) @(negedge clk);

    // Randomized traffic on every instance.
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 60; i++) begin
        logic [15:0] a;
        a = 16'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) a = a | (16'h0100 << $urandom_range(0, 7));
        h = (i == 59) ? 1'b0 : 1'($urandom_range(0, 1));
        txn(k, 1'($urandom_range(0, 1)), a, 16'($urandom), h, 1'b0, cap);
        if (!h) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (3) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
